multi_freq_generator: RTL and testbench
=======================================

MULTI_FREQ_GENERATOR -- requirements
Module: multi_freq_generator

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent output channels (1..16).
REQ-002 Parameter ACC_WIDTH, default 32, phase-accumulator and increment width (8..32).
REQ-003 Parameter DEFAULT_INC, default 32'd85_899_346, per-channel increment after reset (about 1 MHz at 50 MHz); truncated to ACC_WIDTH.
REQ-004 CLOCK_50M  in  1  system clock; only clock; all logic on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 EN  in  CHANNELS  per-channel run enable.
REQ-007 SYNC  in  1  one-cycle pulse; clears all accumulators together for phase alignment.
REQ-008 WR_EN  in  1  increment write strobe.
REQ-009 WR_CH  in  max(1,$clog2(CHANNELS))  target channel of write.
REQ-010 WR_INC  in  ACC_WIDTH  new increment value.
REQ-011 CLK_OUT  out  CHANNELS  approx-50% duty clock per channel (accumulator MSB, registered).
REQ-012 TICK  out  CHANNELS  one-CLOCK_50M-cycle pulse per output period.
REQ-013 PENDING  out  CHANNELS  high while a written increment awaits application.

Function
REQ-014 Each channel SHALL hold acc, active_inc and pending_inc, all ACC_WIDTH wide.
REQ-015 Running (EN=1): acc <= acc + active_inc modulo 2^ACC_WIDTH every cycle; carry = overflow of that add.
REQ-016 TICK[c] SHALL be high exactly in the cycle after a carry on channel c; latency carry->TICK = 1 cycle.
REQ-017 CLK_OUT[c] SHALL equal acc MSB registered once; output frequency = active_inc * 50e6 / 2^ACC_WIDTH.
REQ-018 WR_EN with WR_CH < CHANNELS SHALL load pending_inc and set PENDING[c] next cycle; WR_CH >= CHANNELS ignored.
REQ-019 Running channel: pending_inc SHALL transfer to active_inc only on a carry cycle (glitch-free update); PENDING clears in the same edge.
REQ-020 Write coincident with carry on same channel: transfer uses the old pending_inc; new value stays pending until the next carry.
REQ-021 Stopped channel (EN=0): pending_inc SHALL transfer immediately next cycle; acc, CLK_OUT, TICK forced to 0.
REQ-022 EN 0->1: accumulation starts from acc=0 that cycle; first TICK after ceil(2^ACC_WIDTH/active_inc)+1 cycles.
REQ-023 active_inc=0 SHALL hold acc constant: no ticks, CLK_OUT static, PENDING transfer then only by disabling channel.
REQ-024 SYNC SHALL clear every acc to 0 with no carry or TICK generated that cycle; SYNC overrides the add; pending transfer not triggered.
REQ-025 active_inc >= 2^(ACC_WIDTH-1) permitted; TICK may then assert on consecutive cycles, CLK_OUT duty non-50%.

Reset
REQ-026 RST=1 SHALL set acc=0, active_inc=pending_inc=DEFAULT_INC, CLK_OUT=0, TICK=0, PENDING=0 on next edge.
REQ-027 RST SHALL take priority over SYNC, WR_EN and EN; reset mid-period discards pending writes.

Structure
REQ-028 Package freq_gen_pkg SHALL hold SYS_CLOCK_HZ=50_000_000, default widths, and a constant function inc_for(freq_hz, width).
REQ-029 Per-channel logic SHALL be sub-module nco_channel, instantiated CHANNELS times by generate; top holds write decode only.

Verification
REQ-030 ACC_WIDTH=8, inc=64, EN=1 -> TICK every 4 cycles, CLK_OUT 2 high/2 low.
REQ-031 ACC_WIDTH=8, inc=96 -> TICK intervals 3,3,2 repeating, 3 ticks per 8 cycles.
REQ-032 Running ch0 inc=64, write 32 mid-period -> PENDING=1 until next carry; interval 4 finishes, then 8-cycle intervals; PENDING clears at that carry.
REQ-033 Write coincident with carry -> old pending applied, new value applied at following carry.
REQ-034 Two channels inc=64 and 32 at different phases, SYNC pulse -> both acc=0, next TICKs 4 and 8 cycles later, aligned.
REQ-035 RST asserted mid-period with pending write -> all outputs 0, PENDING=0, active_inc=DEFAULT_INC after release.

Source files
------------

// File: rtl/freq_gen_pkg.sv
// Shared constants and helpers for the multi-channel NCO frequency generator.
// inc_for() converts a target output frequency into a phase increment.
package freq_gen_pkg;

  localparam longint unsigned SYS_CLOCK_HZ      = 64'd50_000_000;
  localparam int unsigned     DEFAULT_CHANNELS  = 2;
  localparam int unsigned     DEFAULT_ACC_WIDTH = 32;
  localparam logic [31:0]     DEFAULT_INC_1MHZ  = 32'd85_899_346;

  // Rounds to the nearest increment: inc = freq * 2^width / SYS_CLOCK_HZ.
  function automatic logic [31:0] inc_for(input longint unsigned freq_hz,
                                          input int unsigned width);
    longint unsigned scaled;
    scaled = ((freq_hz << width) + (SYS_CLOCK_HZ / 2)) / SYS_CLOCK_HZ;
    return scaled[31:0];
  endfunction

endpackage

// File: rtl/nco_channel.sv
// One phase-accumulator channel: accumulator, active/pending increments,
// registered MSB clock output and one-cycle tick on each accumulator wrap.
module nco_channel
  import freq_gen_pkg::*;
#(
  parameter int unsigned            ACC_WIDTH = DEFAULT_ACC_WIDTH,
  parameter logic [ACC_WIDTH-1:0]   RST_INC   = DEFAULT_INC_1MHZ[ACC_WIDTH-1:0]
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_sync,
  input  logic                 i_wr,
  input  logic [ACC_WIDTH-1:0] i_wr_inc,
  output logic                 o_clk_out,
  output logic                 o_tick,
  output logic                 o_pending
);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_active_inc;
  logic [ACC_WIDTH-1:0] r_pending_inc;
  logic                 r_pending;
  logic                 r_clk_out;
  logic                 r_tick;

  logic [ACC_WIDTH:0]   w_sum;
  logic [ACC_WIDTH-1:0] w_acc_d;
  logic                 w_carry;
  logic                 w_load;

  always_comb begin
    w_sum   = {1'b0, r_acc} + {1'b0, r_active_inc};
    w_carry = i_en & ~i_sync & w_sum[ACC_WIDTH];
    w_acc_d = (!i_en || i_sync) ? '0 : w_sum[ACC_WIDTH-1:0];
    // A running channel only swaps increments at a wrap so no period is torn;
    // a stopped channel has no period to protect.
    w_load  = r_pending & (i_en ? w_carry : 1'b1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc         <= '0;
      r_active_inc  <= RST_INC;
      r_pending_inc <= RST_INC;
      r_pending     <= 1'b0;
      r_clk_out     <= 1'b0;
      r_tick        <= 1'b0;
    end else begin
      r_acc     <= w_acc_d;
      r_tick    <= w_carry;
      r_clk_out <= i_en & r_acc[ACC_WIDTH-1];
      if (w_load) begin
        r_active_inc <= r_pending_inc;
      end
      if (i_wr) begin
        r_pending_inc <= i_wr_inc;
      end
      r_pending <= i_wr | (r_pending & ~w_load);
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;
  assign o_pending = r_pending;

endmodule

// File: rtl/multi_freq_generator.sv
// Bank of independent NCO channels sharing a sync pulse and a single
// increment write port; this level only decodes the write target.
module multi_freq_generator
  import freq_gen_pkg::*;
#(
  parameter int unsigned  CHANNELS    = DEFAULT_CHANNELS,
  parameter int unsigned  ACC_WIDTH   = DEFAULT_ACC_WIDTH,
  parameter logic [31:0]  DEFAULT_INC = 32'd85_899_346,
  localparam int unsigned WR_CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 CLOCK_50M,
  input  logic                 RST,
  input  logic [CHANNELS-1:0]  EN,
  input  logic                 SYNC,
  input  logic                 WR_EN,
  input  logic [WR_CH_W-1:0]   WR_CH,
  input  logic [ACC_WIDTH-1:0] WR_INC,
  output logic [CHANNELS-1:0]  CLK_OUT,
  output logic [CHANNELS-1:0]  TICK,
  output logic [CHANNELS-1:0]  PENDING
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic w_wr;
    // Channel numbers beyond CHANNELS never match, so such writes are dropped.
    assign w_wr = WR_EN && (WR_CH == WR_CH_W'(c));

    nco_channel #(
      .ACC_WIDTH (ACC_WIDTH),
      .RST_INC   (DEFAULT_INC[ACC_WIDTH-1:0])
    ) u_nco_channel (
      .i_clk     (CLOCK_50M),
      .i_rst     (RST),
      .i_en      (EN[c]),
      .i_sync    (SYNC),
      .i_wr      (w_wr),
      .i_wr_inc  (WR_INC),
      .o_clk_out (CLK_OUT[c]),
      .o_tick    (TICK[c]),
      .o_pending (PENDING[c])
    );
  end

endmodule

// File: tb/tb_multi_freq_generator.sv
// Directed bench for multi_freq_generator at ACC_WIDTH=8 with three channels,
// so that out-of-range write channels can be exercised.
module tb_multi_freq_generator;

  localparam int unsigned CH = 3;
  localparam int unsigned AW = 8;

  logic          CLOCK_50M = 1'b0;
  logic          RST;
  logic [CH-1:0] EN;
  logic          SYNC;
  logic          WR_EN;
  logic [1:0]    WR_CH;
  logic [AW-1:0] WR_INC;
  logic [CH-1:0] CLK_OUT;
  logic [CH-1:0] TICK;
  logic [CH-1:0] PENDING;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] tk0, tk1, pd0, ck0;

  multi_freq_generator #(
    .CHANNELS    (CH),
    .ACC_WIDTH   (AW),
    .DEFAULT_INC (32'd85_899_346)
  ) dut (
    .CLOCK_50M (CLOCK_50M),
    .RST       (RST),
    .EN        (EN),
    .SYNC      (SYNC),
    .WR_EN     (WR_EN),
    .WR_CH     (WR_CH),
    .WR_INC    (WR_INC),
    .CLK_OUT   (CLK_OUT),
    .TICK      (TICK),
    .PENDING   (PENDING)
  );

  always #5 CLOCK_50M = ~CLOCK_50M;

  task step();
    @(posedge CLOCK_50M);
    #1;
  endtask

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  // Steps n cycles, shifting per-cycle samples in with the first sample as MSB.
  task collect(input int n);
    tk0 = '0; tk1 = '0; pd0 = '0; ck0 = '0;
    for (int i = 0; i < n; i++) begin
      step();
      tk0 = {tk0[30:0], TICK[0]};
      tk1 = {tk1[30:0], TICK[1]};
      pd0 = {pd0[30:0], PENDING[0]};
      ck0 = {ck0[30:0], CLK_OUT[0]};
    end
  endtask

  task write(input logic [1:0] ch, input logic [AW-1:0] inc);
    WR_EN  = 1'b1;
    WR_CH  = ch;
    WR_INC = inc;
  endtask

  initial begin
    RST = 1'b1; EN = '0; SYNC = 1'b0; WR_EN = 1'b0; WR_CH = '0; WR_INC = '0;
    step();
    step();
    chk("rst_clk_out", 32'(CLK_OUT), 32'd0);
    chk("rst_tick", 32'(TICK), 32'd0);
    chk("rst_pending", 32'(PENDING), 32'd0);
    RST = 1'b0;

    // Stopped channel: write applies on the following edge.
    write(2'd0, 8'd64);
    step();
    WR_EN = 1'b0;
    chk("stopped_pending_set", 32'(PENDING), 32'b001);
    step();
    chk("stopped_pending_clear", 32'(PENDING), 32'b000);

    // inc=64: tick every 4 cycles, clock 2 high / 2 low.
    EN = 3'b001;
    collect(8);
    chk("inc64_tick", tk0, 32'b00010001);
    chk("inc64_clk", ck0, 32'b00110011);
    collect(8);
    chk("inc64_tick_cont", tk0, 32'b00010001);
    chk("inc64_clk_cont", ck0, 32'b00110011);

    // inc=96 on ch1: intervals 3,3,2 repeating.
    write(2'd1, 8'd96);
    step();
    WR_EN = 1'b0;
    chk("ch1_pending_set", 32'(PENDING), 32'b010);
    step();
    chk("ch1_pending_clear", 32'(PENDING), 32'b000);
    EN = 3'b011;
    collect(16);
    chk("inc96_tick", tk1, 32'b0010010100100101);
    EN = 3'b001;
    step();
    chk("disabled_clk_out", 32'(CLK_OUT[1]), 32'd0);
    chk("disabled_tick", 32'(TICK[1]), 32'd0);

    // Mid-period write on running ch0 waits for the carry.
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    step();
    write(2'd0, 8'd32);
    step();
    WR_EN = 1'b0;
    chk("midwrite_pending", 32'(PENDING[0]), 32'd1);
    collect(2);
    chk("midwrite_tick_a", tk0, 32'b01);
    chk("midwrite_pend_a", pd0, 32'b10);
    collect(16);
    chk("midwrite_tick_b", tk0, 32'b0000000100000001);
    chk("midwrite_pend_b", pd0, 32'd0);

    // Write coincident with carry: old pending applied, new stays pending.
    write(2'd0, 8'd64);
    step();
    WR_EN = 1'b0;
    repeat (6) step();
    chk("coinc_pending_before", 32'(PENDING[0]), 32'd1);
    write(2'd0, 8'd16);
    step();
    WR_EN = 1'b0;
    chk("coinc_tick", 32'(TICK[0]), 32'd1);
    chk("coinc_pending_kept", 32'(PENDING[0]), 32'd1);
    collect(4);
    chk("coinc_tick_64", tk0, 32'b0001);
    chk("coinc_pend_64", pd0, 32'b1110);
    collect(16);
    chk("coinc_tick_16", tk0, 32'b0000000000000001);
    chk("coinc_pend_16", pd0, 32'd0);

    // Out-of-range channel ignored, then SYNC alignment of two channels.
    EN = 3'b000;
    write(2'd3, 8'd8);
    step();
    chk("wr_ch_out_of_range", 32'(PENDING), 32'd0);
    write(2'd0, 8'd64);
    step();
    chk("two_wr_ch0", 32'(PENDING), 32'b001);
    write(2'd1, 8'd32);
    step();
    WR_EN = 1'b0;
    chk("two_wr_ch1", 32'(PENDING), 32'b010);
    step();
    chk("two_wr_done", 32'(PENDING), 32'b000);
    EN = 3'b001;
    step();
    EN = 3'b011;
    step();
    step();
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    chk("sync_no_tick", 32'(TICK), 32'd0);
    collect(8);
    chk("sync_tick_ch0", tk0, 32'b00010001);
    chk("sync_tick_ch1", tk1, 32'b00000001);

    // Reset mid-period with a pending write; reset beats write/enable.
    write(2'd0, 8'd32);
    step();
    WR_EN = 1'b0;
    chk("pre_rst_pending", 32'(PENDING), 32'b001);
    step();
    RST = 1'b1;
    write(2'd1, 8'd5);
    step();
    chk("mid_rst_clk_out", 32'(CLK_OUT), 32'd0);
    chk("mid_rst_tick", 32'(TICK), 32'd0);
    chk("mid_rst_pending", 32'(PENDING), 32'd0);
    RST = 1'b0;
    WR_EN = 1'b0;
    // Default increment truncated to 8 bits is 0x52 = 82.
    collect(10);
    chk("post_rst_tick_ch0", tk0, 32'b0001001001);
    chk("post_rst_tick_ch1", tk1, 32'b0001001001);
    chk("post_rst_pend", pd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
